// File: rtl/lcm_range_pkg.sv
// Shared types and constants for the LCM(1..N) sequencer.
// Optional feature macro: LCM_RANGE_CYCLE_CNT_EN (adds the cycles counter).
package lcm_range_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_N_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MOD  = 3'd1,
    STEP = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Remainders are strictly below k < 2**n_width; one spare bit keeps the
  // running sum rr + rm (< 2k) representable without wrap.
  function automatic int rem_width(input int n_width);
    return n_width + 1;
  endfunction

endpackage

// File: rtl/lcm_range_seq_if.sv
// Start/done handshake bundle for lcm_range_seq.
// Carries the cycles port only when LCM_RANGE_CYCLE_CNT_EN is defined.
interface lcm_range_seq_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 6
) ();

  logic               start;
  logic [N_WIDTH-1:0] n_max;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               overflow;
`ifdef LCM_RANGE_CYCLE_CNT_EN
  logic [31:0]        cycles;
`endif

`ifdef LCM_RANGE_CYCLE_CNT_EN
  modport master (output start, n_max, input busy, done, result, overflow, cycles);
  modport slave  (input start, n_max, output busy, done, result, overflow, cycles);
`else
  modport master (output start, n_max, input busy, done, result, overflow);
  modport slave  (input start, n_max, output busy, done, result, overflow);
`endif

endinterface

// File: rtl/lcm_range_seq_mod_unit.sv
// Sequential restoring remainder: rem = dividend mod divisor.
// A go pulse loads the operands; the remainder is presented combinationally
// together with valid during the WIDTH-th processing cycle, so the caller
// can act on it without an extra register stage.
module lcm_mod_unit
  import lcm_range_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int N_WIDTH = DEFAULT_N_WIDTH,
  localparam int RW     = rem_width(N_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [N_WIDTH-1:0] divisor,
  output logic [RW-1:0]      rem,
  output logic               valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   shift_reg;
  logic [RW-1:0]      rem_reg;
  logic [N_WIDTH-1:0] div_reg;
  logic [CW-1:0]      cnt_reg;
  logic [RW:0]        trial;
  logic [RW-1:0]      rem_step;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_reg, shift_reg[WIDTH-1]};
    rem_step = trial[RW-1:0];
    if (trial >= {2'b00, div_reg}) begin
      rem_step = RW'(trial - {2'b00, div_reg});
    end
  end

  assign rem   = rem_step;
  assign valid = (cnt_reg == CW'(1));

  // Operand load on go, then one dividend bit per cycle, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      cnt_reg   <= '0;
    end else if (go) begin
      shift_reg <= dividend;
      rem_reg   <= '0;
      div_reg   <= divisor;
      cnt_reg   <= CW'(WIDTH);
    end else if (cnt_reg != '0) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      rem_reg   <= rem_step;
      cnt_reg   <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/lcm_range_seq.sv
// LCM(1..N) sequencer: r := lcm(r,k) for k = 2..N using a shift-subtract
// remainder and an accumulate loop (no divider, no multiplier).
// Define LCM_RANGE_CYCLE_CNT_EN to add the saturating cycles counter.
module lcm_range_seq
  import lcm_range_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int N_WIDTH = DEFAULT_N_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  lcm_range_seq_if.slave bus
);

  localparam int RW = rem_width(N_WIDTH);

  state_t             state_reg, state_next;
  logic [N_WIDTH-1:0] n_reg, n_next;
  logic [N_WIDTH-1:0] k_reg, k_next;
  logic [WIDTH-1:0]   r_reg, r_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [RW-1:0]      rm_reg, rm_next;
  logic [RW-1:0]      rr_reg, rr_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               overflow_reg, overflow_next;

  logic               mod_go;
  logic [WIDTH-1:0]   mod_dividend;
  logic [N_WIDTH-1:0] mod_divisor;
  logic [RW-1:0]      mod_rem;
  logic               mod_valid;

  logic [WIDTH:0]     acc_sum;
  logic [RW-1:0]      rr_sum;
  logic [RW-1:0]      rr_new;

  lcm_mod_unit #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) u_mod (
    .clk      (clk),
    .rst      (rst),
    .go       (mod_go),
    .dividend (mod_dividend),
    .divisor  (mod_divisor),
    .rem      (mod_rem),
    .valid    (mod_valid)
  );

  // Next-state and datapath updates; acc tracks r*j, rr tracks (r*j) mod k.
  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    k_next        = k_reg;
    r_next        = r_reg;
    acc_next      = acc_reg;
    rm_next       = rm_reg;
    rr_next       = rr_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    mod_go        = 1'b0;
    mod_dividend  = r_reg;
    mod_divisor   = k_reg + N_WIDTH'(1);
    acc_sum       = {1'b0, acc_reg} + {1'b0, r_reg};
    rr_sum        = rr_reg + rm_reg;
    rr_new        = rr_sum;
    if (rr_sum >= RW'(k_reg)) begin
      rr_new = rr_sum - RW'(k_reg);
    end

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          n_next        = bus.n_max;
          r_next        = WIDTH'(1);
          k_next        = N_WIDTH'(2);
          overflow_next = 1'b0;
          if (bus.n_max <= N_WIDTH'(1)) begin
            result_next = WIDTH'(1);
            state_next  = DONE;
          end else begin
            mod_go       = 1'b1;
            mod_dividend = WIDTH'(1);
            mod_divisor  = N_WIDTH'(2);
            state_next   = MOD;
          end
        end
      end
      MOD: begin
        if (mod_valid) begin
          if (mod_rem == '0) begin
            state_next = NEXT;
          end else begin
            acc_next   = r_reg;
            rm_next    = mod_rem;
            rr_next    = mod_rem;
            state_next = STEP;
          end
        end
      end
      STEP: begin
        if (acc_sum[WIDTH]) begin
          overflow_next = 1'b1;
          result_next   = '0;
          state_next    = DONE;
        end else if (rr_new == '0) begin
          r_next     = acc_sum[WIDTH-1:0];
          state_next = NEXT;
        end else begin
          acc_next = acc_sum[WIDTH-1:0];
          rr_next  = rr_new;
        end
      end
      NEXT: begin
        if (k_reg == n_reg) begin
          result_next = r_reg;
          state_next  = DONE;
        end else begin
          k_next     = k_reg + N_WIDTH'(1);
          mod_go     = 1'b1;
          state_next = MOD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; rst aborts any run without an output pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      k_reg        <= '0;
      r_reg        <= '0;
      acc_reg      <= '0;
      rm_reg       <= '0;
      rr_reg       <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      k_reg        <= k_next;
      r_reg        <= r_next;
      acc_reg      <= acc_next;
      rm_reg       <= rm_next;
      rr_reg       <= rr_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.busy     = (state_reg == MOD) || (state_reg == STEP) || (state_reg == NEXT);
  assign bus.done     = (state_reg == DONE);
  assign bus.result   = result_reg;
  assign bus.overflow = overflow_reg;

`ifdef LCM_RANGE_CYCLE_CNT_EN
  logic [31:0] cycles_reg;

  // Counts busy cycles of the current run; cleared on accept, frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_reg <= '0;
    end else if ((state_reg == IDLE || state_reg == DONE) && bus.start) begin
      cycles_reg <= '0;
    end else if (bus.busy && (cycles_reg != '1)) begin
      cycles_reg <= cycles_reg + 32'd1;
    end
  end

  assign bus.cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_lcm_range_seq.sv
// Directed self-checking bench for lcm_range_seq (WIDTH=32, N_WIDTH=6).
// With LCM_RANGE_CYCLE_CNT_EN defined the cycles port is also checked.
module tb_lcm_range_seq;

  localparam int WIDTH   = 32;
  localparam int N_WIDTH = 6;
  localparam int TIMEOUT = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  lcm_range_seq_if #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) bus ();

  lcm_range_seq #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle and wait (bounded) for done; cyc counts
  // sampling points from the accept edge up to and including DONE entry.
  task automatic run_n(input int n, output int cyc, output bit ok);
    @(negedge clk);
    bus.n_max = N_WIDTH'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = bus.done;
  endtask

  task automatic check_run(input string name, input int n, input logic [WIDTH-1:0] exp_res,
                           input logic exp_ov);
    int cyc;
    bit ok;
    run_n(n, cyc, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done n=%0d: done=%b after %0d cycles, required 1", name, n, bus.done, cyc);
    end
    n_checks++;
    if (bus.overflow !== exp_ov) begin
      n_fail++;
      $display("FAIL %s_overflow n=%0d: got %b, required %b", name, n, bus.overflow, exp_ov);
    end
    n_checks++;
    if (bus.result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result n=%0d: got %0d, required %0d", name, n, bus.result, exp_res);
    end
    $display("run %s n=%0d: result=%0d overflow=%b cycles=%0d", name, n, bus.result, bus.overflow, cyc);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.n_max = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b result=%0d, required all 0",
               bus.busy, bus.done, bus.overflow, bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    int  cyc;
    bit  seen_busy;
    @(negedge clk);
    bus.n_max = N_WIDTH'(10);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen_busy = bus.busy;
    n_checks++;
    if (seen_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b, required 1", seen_busy);
    end
    cyc = 1;
    while (!bus.done && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_low_with_done: done=%b busy=%b, required done=1 busy=0", bus.done, bus.busy);
    end
    n_checks++;
    if (bus.result !== 32'd2520 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL lcm10: result=%0d ovf=%b, required 2520 ovf=0", bus.result, bus.overflow);
    end
    $display("run basic n=10: result=%0d cycles=%0d", bus.result, cyc);
  endtask

  task automatic test_larger();
    check_run("lcm20", 20, 32'd232792560, 1'b0);
    check_run("lcm22", 22, 32'd232792560, 1'b0);
  endtask

  task automatic test_overflow();
    check_run("lcm23_ovf", 23, 32'd0, 1'b1);
    check_run("lcm5_after_ovf", 5, 32'd60, 1'b0);
  endtask

  task automatic test_small_n();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      bus.n_max = N_WIDTH'(n);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b1 || bus.result !== 32'd1 || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL small_n%0d: done=%b result=%0d ovf=%b, required done=1 result=1 ovf=0",
                 n, bus.done, bus.result, bus.overflow);
      end
      $display("run small n=%0d: done=%b result=%0d", n, bus.done, bus.result);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    @(negedge clk);
    bus.n_max = N_WIDTH'(10);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.n_max = N_WIDTH'(3);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored_busy: busy=%b, required 1", bus.busy);
    end
    cyc = 0;
    while (!bus.done && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.result !== 32'd2520) begin
      n_fail++;
      $display("FAIL busy_start_ignored_result: done=%b result=%0d, required done=1 result=2520",
               bus.done, bus.result);
    end
    $display("run start-while-busy: result=%0d", bus.result);
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.n_max = N_WIDTH'(20);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b ovf=%b result=%0d, required all 0",
               bus.busy, bus.done, bus.overflow, bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("abort mid-MOD: busy=%b done=%b result=%0d", bus.busy, bus.done, bus.result);
    check_run("lcm6_after_abort", 6, 32'd60, 1'b0);
  endtask

  task automatic test_latency();
    int cyc;
    bit ok;
    int exp_cyc;
    // Accept, then per k: WIDTH MOD cycles + steps + 1 NEXT cycle.
    // k=2 from r=1: one step.  k=3 from r=2: two steps (4, 6).
    run_n(2, cyc, ok);
    exp_cyc = 1 + (WIDTH + 1 + 1);
    n_checks++;
    if (!ok || cyc != exp_cyc || bus.result !== 32'd2) begin
      n_fail++;
      $display("FAIL latency_n2: cycles=%0d result=%0d, required cycles=%0d result=2", cyc, bus.result, exp_cyc);
    end
`ifdef LCM_RANGE_CYCLE_CNT_EN
    n_checks++;
    if (bus.cycles !== 32'(WIDTH + 1 + 1)) begin
      n_fail++;
      $display("FAIL cycles_port_n2: got %0d, required %0d", bus.cycles, WIDTH + 2);
    end
`endif
    $display("latency n=2: cycles=%0d", cyc);
    run_n(3, cyc, ok);
    exp_cyc = 1 + (WIDTH + 1 + 1) + (WIDTH + 2 + 1);
    n_checks++;
    if (!ok || cyc != exp_cyc || bus.result !== 32'd6) begin
      n_fail++;
      $display("FAIL latency_n3: cycles=%0d result=%0d, required cycles=%0d result=6", cyc, bus.result, exp_cyc);
    end
    $display("latency n=3: cycles=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_larger();
    test_overflow();
    test_small_n();
    test_start_while_busy();
    test_abort();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
